// File: rtl/lcd_lh507x_pkg.sv
// Shared types and default timing for the LH507x LCD timing generator.
package lcd_lh507x_pkg;

    typedef enum logic [1:0] {
        OFF,
        WAIT_FRAME,
        ACTIVE,
        VBLANK
    } lcd_state_t;

    localparam int unsigned H_ACTIVE_DEF = 160;
    localparam int unsigned H_BLANK_DEF  = 296;
    localparam int unsigned V_ACTIVE_DEF = 144;
    localparam int unsigned V_BLANK_DEF  = 10;
    localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_BLANK_DEF;
    localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_BLANK_DEF;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned COL_W_DEF  = cnt_width(H_TOTAL_DEF);
    localparam int unsigned LINE_W_DEF = cnt_width(V_TOTAL_DEF);

endpackage

// File: rtl/lcd_lh507x_timing_cnt.sv
// Column/line raster counters with synchronous clear and decoded slot strobes.
module lcd_lh507x_timing_cnt
    import lcd_lh507x_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_TOTAL  = H_TOTAL_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_TOTAL  = V_TOTAL_DEF,
    parameter int unsigned COL_W    = COL_W_DEF,
    parameter int unsigned LINE_W   = LINE_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic line_wrap,
    output logic act_end,
    output logic col0,
    output logic col_latch,
    output logic visible,
    output logic line0,
    output logic vis_nxt
);

    logic [COL_W-1:0]  col;
    logic [COL_W-1:0]  col_nxt;
    logic [LINE_W-1:0] line;
    logic [LINE_W-1:0] line_nxt;
    logic              col_wrap;

    assign col_wrap  = (32'(col) == H_TOTAL - 1);
    assign line_wrap = col_wrap && (32'(line) == V_TOTAL - 1);
    assign act_end   = col_wrap && (32'(line) == V_ACTIVE - 1);
    assign col0      = (col == '0);
    assign col_latch = (32'(col) == H_ACTIVE);
    assign visible   = (32'(col) < H_ACTIVE);
    assign line0     = (line == '0);
    // Lets the owner register px_ready against the slot it will govern.
    assign vis_nxt   = (32'(col_nxt) < H_ACTIVE);

    always_comb begin
        col_nxt  = col;
        line_nxt = line;
        if (clr) begin
            col_nxt  = '0;
            line_nxt = '0;
        end else if (en) begin
            if (col_wrap) begin
                col_nxt  = '0;
                line_nxt = line_wrap ? '0 : line + LINE_W'(1);
            end else begin
                col_nxt = col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col  <= '0;
            line <= '0;
        end else begin
            col  <= col_nxt;
            line <= line_nxt;
        end
    end

endmodule

// File: rtl/lcd_lh507x_drv.sv
// LH507x timing generator: frame FSM plus registered posedge/negedge phase pairs
// for every LCD control pin and the 2-bit pixel bus.
module lcd_lh507x_drv
    import lcd_lh507x_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_BLANK  = H_BLANK_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_BLANK  = V_BLANK_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       disp_on,
    input  logic [1:0] px_data,
    input  logic       px_first,
    input  logic       px_valid,
    output logic       px_ready,
    output logic       underrun,
    output logic       p_hsync,
    output logic       n_hsync,
    output logic       p_vsync,
    output logic       n_vsync,
    output logic       p_latch,
    output logic       n_latch,
    output logic       p_altsig,
    output logic       n_altsig,
    output logic       p_ctrl,
    output logic       n_ctrl,
    output logic       p_pclk,
    output logic       n_pclk,
    output logic [1:0] p_px,
    output logic [1:0] n_px
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_BLANK;

    lcd_state_t state, state_nxt;

    logic start, slot, emit, cnt_clr, cnt_en;
    logic line_wrap, act_end, col0, col_latch, visible, line0, vis_nxt;
    logic hsync_d, vsync_d, latch_d, altsig_d, ctrl_d, pclk_d, underrun_d, ready_d;
    logic [1:0] px_d;

    // The WAIT_FRAME cycle that sees the px_first beat is itself slot (0,0).
    assign start   = (state == WAIT_FRAME) && px_valid && px_first;
    assign slot    = (state == ACTIVE) || start;
    assign emit    = slot && visible && disp_on;
    assign cnt_clr = (state == OFF) || ((state == WAIT_FRAME) && !start);
    assign cnt_en  = (state == ACTIVE) || (state == VBLANK) || start;

    lcd_lh507x_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .V_ACTIVE (V_ACTIVE),
        .V_TOTAL  (V_TOTAL),
        .COL_W    (cnt_width(H_TOTAL)),
        .LINE_W   (cnt_width(V_TOTAL))
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .clr       (cnt_clr),
        .en        (cnt_en),
        .line_wrap (line_wrap),
        .act_end   (act_end),
        .col0      (col0),
        .col_latch (col_latch),
        .visible   (visible),
        .line0     (line0),
        .vis_nxt   (vis_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= OFF;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!disp_on) begin
            state_nxt = OFF;
        end else begin
            case (state)
                OFF:        state_nxt = WAIT_FRAME;
                WAIT_FRAME: if (start) state_nxt = ACTIVE;
                ACTIVE:     if (act_end) state_nxt = (V_BLANK == 0) ? WAIT_FRAME : VBLANK;
                VBLANK:     if (line_wrap) state_nxt = WAIT_FRAME;
                default:    state_nxt = OFF;
            endcase
        end
    end

    always_comb begin
        ready_d    = (state_nxt == WAIT_FRAME) || ((state_nxt == ACTIVE) && vis_nxt);
        ctrl_d     = (state != OFF);
        hsync_d    = 1'b0;
        vsync_d    = 1'b0;
        latch_d    = 1'b0;
        pclk_d     = 1'b0;
        underrun_d = 1'b0;
        px_d       = p_px;
        altsig_d   = p_altsig;
        if (state == OFF) begin
            px_d     = '0;
            altsig_d = 1'b0;
        end else if (slot) begin
            hsync_d = col0;
            vsync_d = line0;
            latch_d = col_latch;
            if (col0 && line0) altsig_d = !p_altsig;
            // A beat taken while disp_on is low is dropped rather than shown.
            if (emit) begin
                pclk_d     = 1'b1;
                px_d       = px_valid ? px_data : 2'b00;
                underrun_d = !px_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            px_ready <= 1'b0;
            underrun <= 1'b0;
            p_hsync  <= 1'b0;
            n_hsync  <= 1'b0;
            p_vsync  <= 1'b0;
            n_vsync  <= 1'b0;
            p_latch  <= 1'b0;
            n_latch  <= 1'b0;
            p_altsig <= 1'b0;
            n_altsig <= 1'b0;
            p_ctrl   <= 1'b0;
            n_ctrl   <= 1'b0;
            p_pclk   <= 1'b0;
            n_pclk   <= 1'b0;
            p_px     <= '0;
            n_px     <= '0;
        end else begin
            px_ready <= ready_d;
            underrun <= underrun_d;
            p_hsync  <= hsync_d;
            n_hsync  <= hsync_d;
            p_vsync  <= vsync_d;
            n_vsync  <= vsync_d;
            p_latch  <= latch_d;
            n_latch  <= 1'b0;
            p_altsig <= altsig_d;
            n_altsig <= altsig_d;
            p_ctrl   <= ctrl_d;
            n_ctrl   <= ctrl_d;
            p_pclk   <= pclk_d;
            n_pclk   <= 1'b0;
            p_px     <= px_d;
            n_px     <= px_d;
        end
    end

endmodule

// File: tb/tb_lcd_lh507x_drv.sv
// Directed, table-driven bench for lcd_lh507x_drv on a 7x3 raster (4+3 cols, 2+1 lines).
module tb_lcd_lh507x_drv;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       disp_on = 1'b0;
    logic [1:0] px_data = 2'b00;
    logic       px_first = 1'b0;
    logic       px_valid = 1'b0;
    logic       px_ready, underrun;
    logic       p_hsync, n_hsync, p_vsync, n_vsync, p_latch, n_latch;
    logic       p_altsig, n_altsig, p_ctrl, n_ctrl, p_pclk, n_pclk;
    logic [1:0] p_px, n_px;

    always #5 clk = ~clk;

    lcd_lh507x_drv #(
        .H_ACTIVE (4),
        .H_BLANK  (3),
        .V_ACTIVE (2),
        .V_BLANK  (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .disp_on  (disp_on),
        .px_data  (px_data),
        .px_first (px_first),
        .px_valid (px_valid),
        .px_ready (px_ready),
        .underrun (underrun),
        .p_hsync  (p_hsync),
        .n_hsync  (n_hsync),
        .p_vsync  (p_vsync),
        .n_vsync  (n_vsync),
        .p_latch  (p_latch),
        .n_latch  (n_latch),
        .p_altsig (p_altsig),
        .n_altsig (n_altsig),
        .p_ctrl   (p_ctrl),
        .n_ctrl   (n_ctrl),
        .p_pclk   (p_pclk),
        .n_pclk   (n_pclk),
        .p_px     (p_px),
        .n_px     (n_px)
    );

    // {ready, underrun, hsync p/n, vsync p/n, latch p/n, altsig p/n, ctrl p/n, pclk p/n, px p, px n}
    logic [17:0] bus;
    assign bus = {px_ready, underrun, p_hsync, n_hsync, p_vsync, n_vsync, p_latch, n_latch,
                  p_altsig, n_altsig, p_ctrl, n_ctrl, p_pclk, n_pclk, p_px, n_px};

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    typedef struct {
        logic       d;
        logic       v;
        logic       f;
        logic [1:0] data;
        logic [17:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [17:0] ex(input int r, input int u, input int hs, input int vs,
                                       input int l, input int a, input int c, input int pc,
                                       input int px);
        logic [1:0] p2;
        p2 = 2'(px);
        return {r != 0, u != 0, hs != 0, hs != 0, vs != 0, vs != 0, l != 0, 1'b0,
                a != 0, a != 0, c != 0, c != 0, pc != 0, 1'b0, p2, p2};
    endfunction

    task automatic add(input int d, input int v, input int f, input int data,
                       input int r, input int u, input int hs, input int vs,
                       input int l, input int a, input int c, input int pc, input int px);
        vec_t e;
        e.d    = (d != 0);
        e.v    = (v != 0);
        e.f    = (f != 0);
        e.data = 2'(data);
        e.exp  = ex(r, u, hs, vs, l, a, c, pc, px);
        tbl.push_back(e);
    endtask

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", name, act, exp);
        end
    endtask

    initial begin
        bit found;

        // Rows: inputs (disp_on, valid, first, data) | outputs seen this cycle
        // (ready, underrun, hsync, vsync, latch, altsig, ctrl, pclk, px).
        // Frame 1: beats 0,1,2,3,3,2,1,0.
        add(1,0,0,0, 0,0,0,0,0,0,0,0,0);
        add(1,1,1,0, 1,0,0,0,0,0,0,0,0);
        add(1,1,0,1, 1,0,1,1,0,1,1,1,0);
        add(1,1,0,2, 1,0,0,1,0,1,1,1,1);
        add(1,1,0,3, 1,0,0,1,0,1,1,1,2);
        add(1,1,0,3, 0,0,0,1,0,1,1,1,3);
        add(1,1,0,3, 0,0,0,1,1,1,1,0,3);
        add(1,1,0,3, 0,0,0,1,0,1,1,0,3);
        add(1,1,0,3, 1,0,0,1,0,1,1,0,3);
        add(1,1,0,2, 1,0,1,0,0,1,1,1,3);
        add(1,1,0,1, 1,0,0,0,0,1,1,1,2);
        add(1,1,0,0, 1,0,0,0,0,1,1,1,1);
        add(1,0,0,0, 0,0,0,0,0,1,1,1,0);
        add(1,0,0,0, 0,0,0,0,1,1,1,0,0);
        for (int k = 0; k < 8; k++) add(1,0,0,0, 0,0,0,0,0,1,1,0,0);
        // Frame 2 starts 21 cycles after frame 1; altsig falls back to 0.
        add(1,1,1,2, 1,0,0,0,0,1,1,0,0);
        add(1,1,0,1, 1,0,1,1,0,0,1,1,2);
        // disp_on dropped mid-line with a transfer: beat 3 is swallowed.
        add(0,1,0,3, 1,0,0,1,0,0,1,1,1);
        add(0,0,0,0, 0,0,0,1,0,0,1,0,1);
        add(0,0,0,0, 0,0,0,0,0,0,0,0,0);
        add(1,0,0,0, 0,0,0,0,0,0,0,0,0);
        // Re-enable: three head beats without px_first are discarded.
        add(1,1,0,1, 1,0,0,0,0,0,0,0,0);
        add(1,1,0,3, 1,0,0,0,0,0,1,0,0);
        add(1,1,0,3, 1,0,0,0,0,0,1,0,0);
        add(1,1,1,2, 1,0,0,0,0,0,1,0,0);
        add(1,1,0,1, 1,0,1,1,0,1,1,1,2);
        add(1,1,0,3, 1,0,0,1,0,1,1,1,1);
        add(1,1,0,0, 1,0,0,1,0,1,1,1,3);
        add(1,1,0,2, 0,0,0,1,0,1,1,1,0);
        add(1,1,0,2, 0,0,0,1,1,1,1,0,0);
        add(1,1,0,2, 0,0,0,1,0,1,1,0,0);
        add(1,1,0,2, 1,0,0,1,0,1,1,0,0);
        // Line 1: valid dropped at col 2 -> px 0 with pclk, one underrun pulse.
        add(1,1,0,1, 1,0,1,0,0,1,1,1,2);
        add(1,0,0,0, 1,0,0,0,0,1,1,1,1);
        add(1,1,0,3, 1,1,0,0,0,1,1,1,0);
        add(1,0,0,0, 0,0,0,0,0,1,1,1,3);
        add(1,0,0,0, 0,0,0,0,1,1,1,0,3);
        add(1,0,0,0, 0,0,0,0,0,1,1,0,3);
        add(1,0,0,0, 0,0,0,0,0,1,1,0,3);

        // Reset asserted asynchronously from time 1.
        #1 reset = 1'b0;
        #1 check("reset_state", bus, '0);
        repeat (3) begin
            @(negedge clk);
            check("reset_hold", bus, '0);
        end

        @(posedge clk);
        #1;
        reset    = 1'b1;
        px_valid = 1'b1;
        px_first = 1'b1;
        px_data  = 2'd3;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            check("idle_off", bus, '0);
        end

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            disp_on  = tbl[i].d;
            px_valid = tbl[i].v;
            px_first = tbl[i].f;
            px_data  = tbl[i].data;
            @(negedge clk);
            check($sformatf("tbl[%0d]", i), bus, tbl[i].exp);
        end

        // Async reset in the middle of a visible line.
        @(posedge clk);
        #1;
        disp_on  = 1'b1;
        px_valid = 1'b1;
        px_first = 1'b1;
        px_data  = 2'd3;
        found    = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (p_pclk) found = 1'b1;
        end
        check("pclk_before_reset", {17'b0, found}, 18'd1);
        @(posedge clk);
        #2;
        check("ctrl_before_reset", {17'b0, p_ctrl}, 18'd1);
        reset = 1'b0;
        #1;
        check("async_reset", bus, '0);
        @(posedge clk);
        @(negedge clk);
        check("reset_held", bus, '0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("after_release", bus, '0);
        @(negedge clk);
        check("rewait_ready", bus, ex(1,0,0,0,0,0,0,0,0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_lh507x_drv.md
# lcd_lh507x_drv

Timing generator and pixel-stream adapter for the LH507x reflective LCD path. It accepts 2-bit pixels from the PPU over a valid/ready stream and generates the complete LH507x control set: pixel clock, hsync, vsync, latch, altsig and ctrl. Every signal is produced as a registered posedge/negedge-phase pair (`p_*`/`n_*`), and these pairs feed the pin stage directly. A pin driven from a pair shows `p_x` during the clk-high half and `n_x` during the clk-low half.

## Interface
- `H_ACTIVE`, 160: visible pixels per line.
- `H_BLANK`, 296: idle cycles per line after the visible pixels. `H_TOTAL = H_ACTIVE + H_BLANK`.
- `V_ACTIVE`, 144: visible lines per frame.
- `V_BLANK`, 10: blank lines per frame. `V_TOTAL = V_ACTIVE + V_BLANK`.

Ports:
- `clk` in 1: sole clock, one pixel slot per cycle.
- `reset` in 1: asynchronous, active-low.
- `disp_on` in 1: display enable.
- `px_data` in 2: pixel shade.
- `px_first` in 1: marks the first pixel of a frame; only meaningful with `px_valid`.
- `px_valid` in 1 / `px_ready` out 1: stream handshake. A transfer occurs on a cycle with both high.
- `underrun` out 1: one-cycle pulse when a visible slot had no valid pixel.
- `p_hsync`/`n_hsync`, `p_vsync`/`n_vsync`, `p_latch`/`n_latch`, `p_altsig`/`n_altsig`, `p_ctrl`/`n_ctrl`, `p_pclk`/`n_pclk` out 1 each: LCD control phase pairs.
- `p_px`/`n_px` out 2: pixel data phase pair.

## Operation
- States:
  - OFF: all outputs 0, `px_ready`=0.
  - WAIT_FRAME: `px_ready`=1. Discard stream beats until the head beat has `px_first`=1; do not consume that beat.
  - ACTIVE: visible lines.
  - VBLANK: `px_ready`=0.
- Counters: `col` runs 0..`H_TOTAL`-1 and wraps, incrementing `line` (0..`V_TOTAL`-1, wraps to 0).
- Transitions:
  - OFF → WAIT_FRAME when `disp_on`=1.
  - WAIT_FRAME → ACTIVE on the cycle the head beat is valid with `px_first`=1. Counters load `col`=0, `line`=0, and that beat is consumed as pixel (0,0).
  - ACTIVE → VBLANK when `col` wraps from line `V_ACTIVE`-1.
  - VBLANK → WAIT_FRAME when `line` wraps to 0.
  - Any state → OFF on the cycle after `disp_on`=0. Counters clear and outputs return to 0 one cycle later. There is no graceful line completion.
- In ACTIVE with `col` < `H_ACTIVE`:
  - `px_ready`=1.
  - On transfer: emit `px_data` on both `p_px` and `n_px`, with `p_pclk`=1 and `n_pclk`=0.
  - If `px_valid`=0: emit px=0, still pulse pclk, and pulse `underrun`.
  - `px_first` is ignored after pixel (0,0).
- Elsewhere in ACTIVE: `px_ready`=0, pclk pair 0, px pair holds its last value.
- `hsync` pair is 1/1 for the slot with `col`=0 on every ACTIVE line.
- `latch` pair is `p`=1, `n`=0 for the slot with `col`=`H_ACTIVE` on every ACTIVE line.
- `vsync` pair is 1/1 for every slot of `line` 0.
- `altsig` pair (equal values in both phases) toggles at the start of each frame, i.e. at pixel (0,0).
- `ctrl` pair is 1/1 in every state except OFF.

## Timing
- All outputs are registered. Slot decisions in cycle t appear on the outputs from edge t+1.
- A beat accepted at edge t is on `p_px`/`n_px` from t+1 until the next emitted pixel.
- Reset values: every output is 0, state is OFF, counters are 0, the altsig register is 0.
- Reset takes effect immediately and asynchronously, including mid-line. Release is synchronous to `clk`.
- Frame period is exactly `H_TOTAL`×`V_TOTAL` cycles once ACTIVE is entered. Entry into each frame is gated by WAIT_FRAME alignment.
- `disp_on` low and a transfer in the same cycle: the beat is consumed but not emitted.

## Structure
- Package `lcd_lh507x_pkg` holds:
  - the state enum (OFF, WAIT_FRAME, ACTIVE, VBLANK);
  - default timing constants;
  - counter widths derived as `$clog2(H_TOTAL)` and `$clog2(V_TOTAL)`.
- Sub-module `lcd_lh507x_timing_cnt` holds the col/line counters with synchronous load, wrap flags and decoded slot strobes (`col0`, `col_latch`, `visible`).
- The top level holds the FSM and the output phase registers.

## Test plan
Bench parameters: `H_ACTIVE`=4, `H_BLANK`=3, `V_ACTIVE`=2, `V_BLANK`=1.

- Reset released, `disp_on`=0 → all outputs and `px_ready` stay 0 for 50 cycles.
- `disp_on`=1, stream 8 beats 0,1,2,3,3,2,1,0 with `px_first` on beat 0 →
  - pclk pairs pulse 4 times per line at `col` 0..3;
  - hsync is 1 at `col` 0;
  - latch is `p`=1/`n`=0 at `col` 4;
  - vsync is high for 7 cycles;
  - next frame starts 21 cycles after the first.
- Head beats without `px_first` (3 of them) before a `px_first` beat → all 3 are discarded, and the first emitted pixel is the `px_first` data.
- `px_valid` dropped for `col` 2 of line 1 → px=0 is emitted with pclk, `underrun` pulses once, and the remaining timing is unchanged.
- Two consecutive frames → altsig reads 1 in frame 1 and 0 in frame 2.
- `disp_on` deasserted mid-line, and separately `reset` asserted mid-line →
  - `disp_on` case: outputs are 0 within 2 cycles, then WAIT_FRAME on re-enable;
  - `reset` case: outputs are 0 immediately, asynchronously.
